// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared definitions for the multi-port register file:
//   DEF_DATA_W / DEF_DEPTH : project default register width and entry count
//   state_e                : controller state encoding (INIT clears, RUN serves)
//   addr_ok()              : true when an address names a real, writable entry
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // An address is usable when it lies inside the array and is not the
    // hardwired zero entry (when that option is on).
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input int unsigned depth,
                                     input logic        zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One registered read port of regfile_mp. Selects between the stored entry
// and same-cycle write data (write-first, highest write port wins), forces
// zero for the zero entry, out-of-range addresses and during the init clear.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   rd_en_i        : load a new value into rd_data_o
//   rd_addr_i      : read address
//   init_i         : array is being cleared, return zero
//   mem_data_i     : stored entry at rd_addr_i (don't care when out of range)
//   wr_en_i/wr_addr_i/wr_data_i : all write ports, packed, port j at slice j
//   rd_data_o      : registered read data
// -----------------------------------------------------------------------------
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEF_DEPTH),
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en_i,
    input  logic [ADDR_W-1:0]       rd_addr_i,
    input  logic                    init_i,
    input  logic [DATA_W-1:0]       mem_data_i,
    input  logic [NWR-1:0]          wr_en_i,
    input  logic [NWR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NWR*DATA_W-1:0]   wr_data_i,
    output logic [DATA_W-1:0]       rd_data_o
);

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = mem_data_i;
        // Ascending scan: a later (higher-index) matching port overrides.
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                rd_data_d = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
        // Zero entry and out-of-range reads never expose data, bypass included.
        if (init_i || !addr_ok(32'(rd_addr_i), DEPTH, ZERO_REG != 0)) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parameterised multi-port register file with NRD registered read ports and
// NWR write ports. After reset a controller sweeps the array clearing one
// entry per cycle (busy high); normal access starts once every entry is zero.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   rd_en    : per-port read enable (NRD bits)
//   rd_addr  : read addresses, port i at slice i
//   rd_data  : registered read data, port i at slice i
//   wr_en    : per-port write enable (NWR bits)
//   wr_addr  : write addresses, port j at slice j
//   wr_data  : write data, port j at slice j
//   busy     : high while the init clear is running
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    output logic                    busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [NWR-1:0]    wr_ok;
    logic [DATA_W-1:0] mem_rd [NRD];

    // ---------------- init controller ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_INIT);

    // ---------------- storage ----------------
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = wr_en[j] &&
                       addr_ok(32'(wr_addr[j*ADDR_W +: ADDR_W]), DEPTH, ZERO_REG != 0);
        end
    end

    // Contents are not reset: the controller's sweep is what zeroes them.
    // Writes are applied in ascending port order so the highest port wins.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) begin
                    mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            mem_rd[i] = '0;
            if (32'(rd_addr[i*ADDR_W +: ADDR_W]) < DEPTH) begin
                mem_rd[i] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_en_i    (rd_en[i]),
            .rd_addr_i  (rd_addr[i*ADDR_W +: ADDR_W]),
            .init_i     (busy),
            .mem_data_i (mem_rd[i]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .rd_data_o  (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Two register files side by side: the default configuration (32 x 32, 2R/2W)
// and a 20-entry, 4-read-port build. A behavioural model tracks the contents
// of each and a compare process checks every read port and busy each cycle;
// directed steps add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus, index [dut][port]
    logic [3:0]  s_rd_en   [2];
    logic [4:0]  s_rd_addr [2][4];
    logic [1:0]  s_wr_en   [2];
    logic [4:0]  s_wr_addr [2][2];
    logic [31:0] s_wr_data [2][2];

    logic [9:0]   rd_addr0;
    logic [19:0]  rd_addr1;
    logic [9:0]   wr_addr0, wr_addr1;
    logic [63:0]  wr_data0, wr_data1;
    logic [63:0]  rd_data0;
    logic [127:0] rd_data1;
    logic         busy0, busy1;
    logic [31:0]  dut_rd [2][4];

    always_comb begin
        rd_addr0 = {s_rd_addr[0][1], s_rd_addr[0][0]};
        rd_addr1 = {s_rd_addr[1][3], s_rd_addr[1][2], s_rd_addr[1][1], s_rd_addr[1][0]};
        wr_addr0 = {s_wr_addr[0][1], s_wr_addr[0][0]};
        wr_addr1 = {s_wr_addr[1][1], s_wr_addr[1][0]};
        wr_data0 = {s_wr_data[0][1], s_wr_data[0][0]};
        wr_data1 = {s_wr_data[1][1], s_wr_data[1][0]};
    end

    always_comb begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++)
                dut_rd[d][p] = '0;
        for (int p = 0; p < 2; p++) dut_rd[0][p] = rd_data0[p*32 +: 32];
        for (int p = 0; p < 4; p++) dut_rd[1][p] = rd_data1[p*32 +: 32];
    end

    regfile_mp dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (s_rd_en[0][1:0]),
        .rd_addr (rd_addr0),
        .rd_data (rd_data0),
        .wr_en   (s_wr_en[0]),
        .wr_addr (wr_addr0),
        .wr_data (wr_data0),
        .busy    (busy0)
    );

    regfile_mp #(.DATA_W(32), .DEPTH(20), .NRD(4), .NWR(2), .ZERO_REG(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (s_rd_en[1]),
        .rd_addr (rd_addr1),
        .rd_data (rd_data1),
        .wr_en   (s_wr_en[1]),
        .wr_addr (wr_addr1),
        .wr_data (wr_data1),
        .busy    (busy1)
    );

    function automatic int dep(input int d);
        return (d == 0) ? 32 : 20;
    endfunction

    function automatic int nrd(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Contents are all zero from reset onwards (the clear finishes before any
    // access is honoured). Each edge in RUN applies writes in port order,
    // then reads see the updated contents.
    logic [31:0] m_mem  [2][32];
    logic [31:0] m_rd   [2][4];
    int          m_init [2];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    for (int a = 0; a < 32; a++) m_mem[d][a] = '0;
                    for (int p = 0; p < 4; p++)  m_rd[d][p]  = '0;
                    m_init[d] = dep(d);
                end else if (m_init[d] > 0) begin
                    for (int p = 0; p < nrd(d); p++)
                        if (s_rd_en[d][p]) m_rd[d][p] = '0;
                    m_init[d]--;
                end else begin
                    for (int j = 0; j < 2; j++) begin
                        int a;
                        a = int'(s_wr_addr[d][j]);
                        if (s_wr_en[d][j] && a != 0 && a < dep(d))
                            m_mem[d][a] = s_wr_data[d][j];
                    end
                    for (int p = 0; p < nrd(d); p++) begin
                        int a;
                        a = int'(s_rd_addr[d][p]);
                        if (s_rd_en[d][p])
                            m_rd[d][p] = (a < dep(d)) ? m_mem[d][a] : 32'd0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #3;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < nrd(d); p++)
                    chk($sformatf("model dut%0d rd%0d", d, p), dut_rd[d][p], m_rd[d][p]);
            end
            chk("model busy0", 32'(busy0), 32'(m_init[0] > 0));
            chk("model busy1", 32'(busy1), 32'(m_init[1] > 0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            s_rd_en[d] = '0;
            s_wr_en[d] = '0;
            for (int p = 0; p < 4; p++) s_rd_addr[d][p] = '0;
            for (int j = 0; j < 2; j++) begin
                s_wr_addr[d][j] = '0;
                s_wr_data[d][j] = '0;
            end
        end
    endtask

    task automatic rd(input int d, input int p, input int a);
        s_rd_en[d][p]   = 1'b1;
        s_rd_addr[d][p] = 5'(a);
    endtask

    task automatic wr(input int d, input int j, input int a, input logic [31:0] v);
        s_wr_en[d][j]   = 1'b1;
        s_wr_addr[d][j] = 5'(a);
        s_wr_data[d][j] = v;
    endtask

    // Let the current inputs be taken by one rising edge; return at the
    // following falling edge with the registered results visible.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100 && busy0; k++) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        idle();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("init_len", 32'(n), 32'd32);

        // Every entry reads zero after the clear.
        for (int a = 0; a < 32; a += 2) begin
            idle(); rd(0, 0, a); rd(0, 1, a + 1); step();
            chk("clear_rd0", dut_rd[0][0], 32'd0);
            chk("clear_rd1", dut_rd[0][1], 32'd0);
        end

        // Write-first bypass.
        idle(); wr(0, 0, 5, 32'hDEADBEEF); rd(0, 1, 5); step();
        chk("bypass", dut_rd[0][1], 32'hDEADBEEF);

        // Two ports write one address: port 1 wins in bypass and storage.
        idle(); wr(0, 0, 7, 32'h11111111); wr(0, 1, 7, 32'h22222222); rd(0, 0, 7); step();
        chk("prio_bypass", dut_rd[0][0], 32'h22222222);
        idle(); rd(0, 1, 7); step();
        chk("prio_store", dut_rd[0][1], 32'h22222222);
        idle(); rd(0, 0, 5); step();
        chk("store5", dut_rd[0][0], 32'hDEADBEEF);

        // Entry 0 is hardwired to zero; port 1 holds while disabled.
        idle(); wr(0, 0, 0, 32'hFFFFFFFF); rd(0, 0, 0); step();
        chk("zero_bypass", dut_rd[0][0], 32'd0);
        idle(); rd(0, 0, 0); step();
        chk("zero_store", dut_rd[0][0], 32'd0);
        chk("hold_rd1", dut_rd[0][1], 32'h22222222);

        // 20-entry build: in-range write seen by all 4 ports, out-of-range dropped.
        idle(); wr(1, 0, 19, 32'h1234); wr(1, 1, 25, 32'hCAFE); step();
        idle(); for (int p = 0; p < 4; p++) rd(1, p, 19); step();
        for (int p = 0; p < 4; p++) chk($sformatf("d20_rd19_p%0d", p), dut_rd[1][p], 32'h1234);
        idle(); wr(1, 1, 25, 32'hBEEF); for (int p = 0; p < 4; p++) rd(1, p, 25); step();
        for (int p = 0; p < 4; p++) chk($sformatf("d20_rd25_p%0d", p), dut_rd[1][p], 32'd0);

        // Reset in RUN wipes everything and reruns the full clear.
        idle(); wr(0, 1, 3, 32'hA5A5A5A5); step();
        idle(); rd(0, 0, 3); rd(0, 1, 3); step();
        chk("store3_rd0", dut_rd[0][0], 32'hA5A5A5A5);
        chk("store3_rd1", dut_rd[0][1], 32'hA5A5A5A5);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_rd0", dut_rd[0][0], 32'd0);
        chk("rst_rd1", dut_rd[0][1], 32'd0);
        chk("rst_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // Reads during the clear return zero; writes during it are ignored.
        rd(0, 0, 3); wr(0, 0, 2, 32'h00000077);
        count_busy(n);
        chk("reinit_len", 32'(n), 32'd32);
        idle(); rd(0, 0, 3); rd(0, 1, 2); step();
        chk("after_rst3", dut_rd[0][0], 32'd0);
        chk("init_wr_dropped", dut_rd[0][1], 32'd0);

        idle();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (any value 2..256).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default 1, where 1 hardwires entry 0 to zero.
REQ-006 SHALL derive local ADDR_W = clog2(DEPTH).
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port rd_en, input, NRD bits: per-port read enable.
REQ-010 SHALL have port rd_addr, input, NRD*ADDR_W bits: read addresses, port i at slice i.
REQ-011 SHALL have port rd_data, output, NRD*DATA_W bits: registered read data.
REQ-012 SHALL have port wr_en, input, NWR bits: per-port write enable.
REQ-013 SHALL have port wr_addr, input, NWR*ADDR_W bits: write addresses.
REQ-014 SHALL have port wr_data, input, NWR*DATA_W bits: write data.
REQ-015 SHALL have port busy, output, 1 bit: high while the init clear runs.

Function
REQ-016 SHALL implement a two-state FSM, INIT and RUN, and SHALL enter INIT on reset.
REQ-017 In INIT, SHALL clear one entry per cycle via a counter 0..DEPTH-1 and go to RUN the cycle after clearing entry DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-018 SHALL drive busy=1 exactly while in INIT.
REQ-019 In INIT, SHALL ignore all writes and SHALL load 0 into any enabled read port.
REQ-020 In RUN, SHALL deliver a read with rd_en[i]=1 at edge N on rd_data[i] after edge N (1-cycle latency).
REQ-021 SHALL hold rd_data[i] unchanged while rd_en[i]=0.
REQ-022 SHALL commit a write with wr_en[j]=1 at the same rising edge.
REQ-023 SHALL resolve a same-cycle read and write of the same address write-first: rd_data returns the new wr_data.
REQ-024 SHALL resolve same-cycle writes to one address by port priority: the highest-index port wins, for both storage and bypass.
REQ-025 With ZERO_REG=1, SHALL drop writes to address 0 and SHALL return 0 for reads of address 0, bypass included.
REQ-026 SHALL drop writes to addresses >= DEPTH and SHALL return 0 for reads of them.
REQ-027 SHALL keep all read ports independent: any NRD ports may read the same address in the same cycle.

Reset
REQ-028 While rst_n=0, SHALL asynchronously force rd_data to 0, busy to 1, the FSM to INIT, and the counter to 0.
REQ-029 SHALL restart the full DEPTH-cycle clear after a reset asserted mid-INIT or mid-RUN; no prior contents survive.
REQ-030 SHALL leave storage contents unspecified until INIT completes (they are cleared by the FSM, not by reset).

Structure
REQ-031 SHALL take default widths (DATA_W, DEPTH) and the FSM state encoding from the shared project macro/parameter file.
REQ-032 SHALL factor the per-read-port bypass and priority mux into one sub-module, regfile_rd_port, instantiated NRD times via generate.
REQ-033 SHALL hold storage as a plain register array (no vendor primitive) so that NWR write ports are legal.

Verification
REQ-034 Bench: release reset -> busy=1 for exactly 32 cycles; then read all 32 addresses -> every rd_data=0.
REQ-035 Bench: write port0 addr5=0xDEADBEEF with a same-cycle read port1 addr5 -> next cycle rd_data[1]=0xDEADBEEF (bypass).
REQ-036 Bench: port0 and port1 both write addr7 (0x11111111 and 0x22222222) -> a later read of addr7=0x22222222.
REQ-037 Bench: write addr0=0xFFFFFFFF -> a same-cycle read and a later read of addr0 both return 0.
REQ-038 Bench: write addr3=0xA5A5A5A5, assert rst_n=0 mid-RUN for 1 cycle -> rd_data=0 immediately; busy=1 for 32 cycles; then addr3 reads 0.
REQ-039 Bench: DEPTH=20, NRD=4: write addr19=0x1234 and addr25 -> all 4 ports reading addr19 return 0x1234 and reads of addr25 return 0.
